// File: rtl/fpu_addsub_arbiter_if.sv
// Bundle of requester, unit-control and response signals for fpu_addsub_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface fpu_addsub_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid_i;
    logic [NREQ-1:0]   req_ready_o;
    logic [NREQ*W-1:0] req_op_a_i;
    logic [NREQ*W-1:0] req_op_b_i;
    logic [NREQ-1:0]   req_sub_i;
    logic              unit_beg_o;
    logic              unit_rst_o;
    logic [W-1:0]      unit_op_a_o;
    logic [W-1:0]      unit_op_b_o;
    logic              unit_sub_o;
    logic              unit_ready_i;
    logic [W-1:0]      unit_result_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [IDW-1:0]    rsp_id_o;
    logic [W-1:0]      rsp_data_o;
    logic              rsp_err_o;
    logic              busy_o;

    modport slave (
        input  req_valid_i, req_op_a_i, req_op_b_i, req_sub_i,
        input  unit_ready_i, unit_result_i, rsp_ready_i,
        output req_ready_o, unit_beg_o, unit_rst_o, unit_op_a_o, unit_op_b_o, unit_sub_o,
        output rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o
    );

    modport master (
        output req_valid_i, req_op_a_i, req_op_b_i, req_sub_i,
        output unit_ready_i, unit_result_i, rsp_ready_i,
        input  req_ready_o, unit_beg_o, unit_rst_o, unit_op_a_o, unit_op_b_o, unit_sub_o,
        input  rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o
    );
endinterface

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter/sequencer sharing one FP add/sub unit among NREQ requesters.
// Optional WAIT watchdog enabled by defining FPU_ADDSUB_ARB_TIMEOUT_EN.
module fpu_addsub_arbiter #(
    parameter int NREQ       = 4,
    parameter int W          = 32,
    parameter int IDW        = 2,
    parameter int TMO_CYCLES = 64
) (
    input logic                 clk,
    input logic                 rst,
    fpu_addsub_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [IDW-1:0]  last_grant_r;
    logic [IDW-1:0]  grant_s;
    logic            any_valid_s;
    logic            accept_s;
    logic            capture_s;
    logic            tmo_hit_s;
    logic            rsp_done_s;
    logic [NREQ-1:0] req_ready_s;
    logic [W-1:0]    op_a_r;
    logic [W-1:0]    op_b_r;
    logic            sub_r;
    logic [IDW-1:0]  id_r;
    logic [W-1:0]    rsp_data_r;
    logic            beg_r;
    logic            urst_r;
    logic            rsp_valid_r;
    logic            busy_r;

    // Nearest valid requester after 'last'; 'last' itself ranks lowest.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  last);
        logic [IDW-1:0] pick;
        int             idx;
        pick = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx  = (int'(last) + k) % NREQ;
            pick = valid[idx] ? IDW'(idx) : pick;
        end
        return pick;
    endfunction

    assign any_valid_s = |bus.req_valid_i;
    assign grant_s     = rr_pick(bus.req_valid_i, last_grant_r);
    assign accept_s    = (state_r == ST_IDLE) && any_valid_s;
    assign capture_s   = (state_r == ST_WAIT) && bus.unit_ready_i;
    assign rsp_done_s  = (state_r == ST_RESP) && bus.rsp_ready_i;

    // Accept strobe goes only to the granted requester, and only while IDLE
    always_comb begin
        req_ready_s = {NREQ{1'b0}};
        if (accept_s) begin
            req_ready_s[grant_s] = 1'b1;
        end else begin
            req_ready_s = {NREQ{1'b0}};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.unit_ready_i || tmo_hit_s) begin
                    next_state_s = ST_RELEASE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RELEASE: begin
                next_state_s = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state so each lines up with its state cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            beg_r       <= 1'b0;
            urst_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            beg_r       <= (next_state_s == ST_ISSUE);
            urst_r      <= (next_state_s == ST_RELEASE);
            rsp_valid_r <= (next_state_s == ST_RESP);
            busy_r      <= (next_state_s != ST_IDLE);
        end
    end

    // Operand/id latch on accept; held untouched until the next accept
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_r       <= {W{1'b0}};
            op_b_r       <= {W{1'b0}};
            sub_r        <= 1'b0;
            id_r         <= {IDW{1'b0}};
            last_grant_r <= IDW'(NREQ - 1);
        end else if (accept_s) begin
            op_a_r       <= bus.req_op_a_i[int'(grant_s)*W +: W];
            op_b_r       <= bus.req_op_b_i[int'(grant_s)*W +: W];
            sub_r        <= bus.req_sub_i[grant_s];
            id_r         <= grant_s;
            last_grant_r <= grant_s;
        end else begin
            op_a_r       <= op_a_r;
            op_b_r       <= op_b_r;
            sub_r        <= sub_r;
            id_r         <= id_r;
            last_grant_r <= last_grant_r;
        end
    end

    // Result capture: a real result wins over a coincident watchdog expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_r <= {W{1'b0}};
        end else if (capture_s) begin
            rsp_data_r <= bus.unit_result_i;
        end else if (tmo_hit_s) begin
            rsp_data_r <= {W{1'b0}};
        end else begin
            rsp_data_r <= rsp_data_r;
        end
    end

`ifdef FPU_ADDSUB_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TMO_CYCLES + 1) > 8) ? $clog2(TMO_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt_r;
    logic             err_r;

    // WAIT-cycle counter; it is already zero on every entry into WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign tmo_hit_s = (state_r == ST_WAIT) && !bus.unit_ready_i &&
                       (wait_cnt_r == CNT_W'(TMO_CYCLES - 1));

    // Error flag lives for exactly one response
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (capture_s) begin
            err_r <= 1'b0;
        end else if (tmo_hit_s) begin
            err_r <= 1'b1;
        end else if (rsp_done_s) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    assign bus.rsp_err_o = err_r;
`else
    assign tmo_hit_s     = 1'b0;
    assign bus.rsp_err_o = 1'b0;
`endif

    assign bus.req_ready_o = req_ready_s;
    assign bus.unit_beg_o  = beg_r;
    assign bus.unit_rst_o  = urst_r;
    assign bus.unit_op_a_o = op_a_r;
    assign bus.unit_op_b_o = op_b_r;
    assign bus.unit_sub_o  = sub_r;
    assign bus.rsp_valid_o = rsp_valid_r;
    assign bus.rsp_id_o    = id_r;
    assign bus.rsp_data_o  = rsp_data_r;
    assign bus.busy_o      = busy_r;

endmodule
